// File: rtl/midi_tx.sv
// MIDI OUT serialiser: sends a {status, data1, data2} message as 1-3 UART frames
// (8N1, LSB first) with optional running-status compression.
module midi_tx #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int BAUD           = 31250,
    parameter int RUNNING_STATUS = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [23:0] msg,
    input  logic        msg_valid,
    output logic        msg_ready,
    output logic        MIDI_OUT,
    output logic        busy
);

    localparam int BIT_CYCLES = CLK_HZ / BAUD;
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DROP} state_t;

    state_t       r_state;
    state_t       w_next;
    logic [CW-1:0] r_baud;
    logic [2:0]   r_bit;
    logic [7:0]   r_shift;
    logic [15:0]  r_buf;
    logic [1:0]   r_left;
    logic [7:0]   r_held;
    logic         r_held_vld;
    logic         r_out;

    logic         w_accept;
    logic         w_bit_done;
    logic [7:0]   w_status;
    logic [1:0]   w_len;
    logic         w_chan;
    logic         w_skip;
    logic [23:0]  w_bytes;
    logic [1:0]   w_count;

    assign msg_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign MIDI_OUT   = r_out;
    assign w_accept   = msg_valid && msg_ready;
    assign w_bit_done = (r_baud == '0);
    assign w_status   = msg[23:16];

    always_comb begin
        w_len = 2'd0;
        case (w_status[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: w_len = 2'd3;
            4'hC, 4'hD:                   w_len = 2'd2;
            4'hF: begin
                case (w_status[3:0])
                    4'h1, 4'h3: w_len = 2'd2;
                    4'h2:       w_len = 2'd3;
                    default:    w_len = 2'd1;
                endcase
            end
            default: w_len = 2'd0;
        endcase
    end

    // Channel messages (80-EF) are the only ones eligible for running status.
    assign w_chan  = w_status[7] && (w_status[7:4] != 4'hF);
    assign w_skip  = (RUNNING_STATUS != 0) && w_chan && r_held_vld && (r_held == w_status);
    assign w_bytes = w_skip ? {msg[15:0], 8'h00} : msg;
    assign w_count = w_skip ? (w_len - 2'd1) : w_len;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = msg[23] ? S_START : S_DROP;
            S_START: if (w_bit_done) w_next = S_DATA;
            S_DATA:  if (w_bit_done && (r_bit == 3'd7)) w_next = S_STOP;
            S_STOP:  if (w_bit_done) w_next = (r_left != 2'd0) ? S_START : S_IDLE;
            S_DROP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_buf   <= '0;
            r_left  <= '0;
            r_out   <= 1'b1;
        end else if (w_accept && msg[23]) begin
            r_baud  <= BAUD_RELOAD;
            r_bit   <= '0;
            r_shift <= w_bytes[23:16];
            r_buf   <= w_bytes[15:0];
            r_left  <= w_count - 2'd1;
            r_out   <= 1'b0;
        end else if (r_state == S_START || r_state == S_DATA || r_state == S_STOP) begin
            if (w_bit_done) begin
                r_baud <= BAUD_RELOAD;
                case (r_state)
                    S_START: begin
                        r_out   <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= '0;
                    end
                    S_DATA: begin
                        if (r_bit == 3'd7) begin
                            r_out <= 1'b1;
                        end else begin
                            r_out   <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                        end
                    end
                    S_STOP: begin
                        // Next start bit follows the stop bit with no idle gap.
                        if (r_left != 2'd0) begin
                            r_out   <= 1'b0;
                            r_shift <= r_buf[15:8];
                            r_buf   <= {r_buf[7:0], 8'h00};
                            r_left  <= r_left - 2'd1;
                        end
                    end
                    default: ;
                endcase
            end else begin
                r_baud <= r_baud - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_held     <= '0;
            r_held_vld <= 1'b0;
        end else if (w_accept && msg[23] && (RUNNING_STATUS != 0)) begin
            if (w_chan) begin
                r_held     <= w_status;
                r_held_vld <= 1'b1;
            end else if (w_status[7:3] == 5'b11110) begin
                r_held_vld <= 1'b0;
            end
        end
    end

endmodule
